// File: rtl/timer_pkg.sv
// Shared types and defaults for the frame/game timer.
//   timer_state_t    : controller states (IDLE, RUN, PAUSE, DONE)
//   TIMER_*          : default parameter values for frame_game_timer
//   beat_cnt_width() : width of a 0..frames-1 counter, never less than 1
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam int TIMER_WIDTH       = 16;
  localparam int TIMER_BEAT_FRAMES = 30;
  localparam int TIMER_BEAT_W      = 8;

  function automatic int beat_cnt_width(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous
// level (vsync-derived frame strobe).
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   async_in   : asynchronous level input
//   rise_pulse : one-cycle pulse, high in the cycle after the synchronised
//                level is first seen high
module frame_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Driven only by flops, so downstream logic sees a clean one-cycle pulse.
  assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/frame_game_timer.sv
// Song/game frame timer: counts synchronised frame edges from a start
// command up to a latched end count, with pause, abort, restart, beat
// pulses and a done pulse.
//   clk, reset  : system clock, asynchronous active-low reset
//   start       : one-cycle start/restart, latches end_count
//   pause       : level, holds the timer while in RUN/PAUSE
//   abort       : one-cycle return to IDLE (beats start)
//   new_frame   : asynchronous frame level, rising edge = one frame
//   end_count   : last frame value
//   un_time     : current frame count
//   frame_tick  : pulse when un_time shows an incremented value
//   beat        : pulse when un_time reaches a nonzero multiple of BEAT_FRAMES
//   beat_idx    : beats since start, wraps
//   running     : high in RUN
//   stop_sign   : high in DONE
//   done_pulse  : one-cycle pulse on entry to DONE
//
// state | meaning
// IDLE  | waiting for start
// RUN   | counting frames
// PAUSE | holding, frame edges discarded
// DONE  | end count reached, un_time held
module frame_game_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = TIMER_WIDTH,
  parameter int BEAT_FRAMES = TIMER_BEAT_FRAMES,
  parameter int BEAT_W      = TIMER_BEAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             new_frame,
  input  logic [WIDTH-1:0] end_count,
  output logic [WIDTH-1:0] un_time,
  output logic             frame_tick,
  output logic             beat,
  output logic [BEAT_W-1:0] beat_idx,
  output logic             running,
  output logic             stop_sign,
  output logic             done_pulse
);

  localparam int CNT_W = beat_cnt_width(BEAT_FRAMES);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_FRAMES - 1);

  timer_state_t      state_q, state_d;
  logic [WIDTH-1:0]  un_time_q, un_time_d;
  logic [WIDTH-1:0]  end_q, end_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
  logic              frame_tick_q, frame_tick_d;
  logic              beat_q, beat_d;
  logic              done_q, done_d;
  logic              tick;

  frame_edge_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (new_frame),
    .rise_pulse (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      un_time_q    <= '0;
      end_q        <= '0;
      beat_cnt_q   <= '0;
      beat_idx_q   <= '0;
      frame_tick_q <= 1'b0;
      beat_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      un_time_q    <= un_time_d;
      end_q        <= end_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_idx_q   <= beat_idx_d;
      frame_tick_q <= frame_tick_d;
      beat_q       <= beat_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    un_time_d    = un_time_q;
    end_d        = end_q;
    beat_cnt_d   = beat_cnt_q;
    beat_idx_d   = beat_idx_q;
    frame_tick_d = 1'b0;
    beat_d       = 1'b0;
    done_d       = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      un_time_d  = '0;
      beat_cnt_d = '0;
      beat_idx_d = '0;
    end else if (start) begin
      // A frame edge in this cycle is deliberately dropped: count restarts at 0.
      state_d    = RUN;
      end_d      = end_count;
      un_time_d  = '0;
      beat_cnt_d = '0;
      beat_idx_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (un_time_q == end_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              un_time_d    = un_time_q + WIDTH'(1);
              frame_tick_d = 1'b1;
              if (beat_cnt_q == BEAT_LAST) begin
                beat_cnt_d = '0;
                beat_d     = 1'b1;
                beat_idx_d = beat_idx_q + BEAT_W'(1);
              end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
              end
            end
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  assign un_time    = un_time_q;
  assign frame_tick = frame_tick_q;
  assign beat       = beat_q;
  assign beat_idx   = beat_idx_q;
  assign running    = (state_q == RUN);
  assign stop_sign  = (state_q == DONE);
  assign done_pulse = done_q;

endmodule

// File: tb/tb_frame_game_timer.sv
module tb_frame_game_timer;

  typedef enum int {A_START, A_FRAME, A_PAUSE_ON, A_PAUSE_OFF,
                    A_ABORT, A_ABORT_START, A_COINCIDE} act_t;

  typedef struct {
    act_t        act;
    logic [15:0] ec;
    int          un;
    int          run;
    int          stop;
    int          tk;
    int          bt;
    int          dn;
    int          idx;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        abort = 1'b0;
  logic        new_frame = 1'b0;
  logic [15:0] end_count = '0;
  logic [15:0] un_time;
  logic        frame_tick, beat, running, stop_sign, done_pulse;
  logic [7:0]  beat_idx;

  int checks = 0;
  int failures = 0;
  int tk_n = 0, bt_n = 0, dn_n = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  frame_game_timer #(.WIDTH(16), .BEAT_FRAMES(3), .BEAT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .new_frame  (new_frame),
    .end_count  (end_count),
    .un_time    (un_time),
    .frame_tick (frame_tick),
    .beat       (beat),
    .beat_idx   (beat_idx),
    .running    (running),
    .stop_sign  (stop_sign),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  // Pulse counters: each cycle a pulse is high adds one.
  always @(negedge clk) begin
    tk_n += int'(frame_tick);
    bt_n += int'(beat);
    dn_n += int'(done_pulse);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic add(input act_t a, input int ec, input int un, input int run,
                     input int stop, input int tk, input int bt, input int dn,
                     input int idx);
    vec_t v;
    v.act = a; v.ec = 16'(ec); v.un = un; v.run = run; v.stop = stop;
    v.tk = tk; v.bt = bt; v.dn = dn; v.idx = idx;
    vecs.push_back(v);
  endtask

  task automatic apply(input act_t a, input logic [15:0] ec);
    tk_n = 0; bt_n = 0; dn_n = 0;
    case (a)
      A_START: begin
        start = 1'b1; end_count = ec; cyc(1);
        start = 1'b0; end_count = ~ec; cyc(1);
      end
      A_FRAME: begin
        new_frame = 1'b1; cyc(4);
        new_frame = 1'b0; cyc(4);
      end
      A_PAUSE_ON:  begin pause = 1'b1; cyc(2); end
      A_PAUSE_OFF: begin pause = 1'b0; cyc(2); end
      A_ABORT: begin
        abort = 1'b1; cyc(1); abort = 1'b0; cyc(1);
      end
      A_ABORT_START: begin
        abort = 1'b1; start = 1'b1; end_count = ec; cyc(1);
        abort = 1'b0; start = 1'b0; end_count = ~ec; cyc(1);
      end
      A_COINCIDE: begin
        // Internal tick lands on the same edge that samples start.
        new_frame = 1'b1; cyc(2);
        start = 1'b1; end_count = ec; cyc(1);
        start = 1'b0; end_count = ~ec;
        chk("coincide_tick_now", int'(frame_tick), 0);
        chk("coincide_un_now", int'(un_time), 0);
        cyc(2);
        new_frame = 1'b0; cyc(4);
      end
      default: ;
    endcase
  endtask

  initial begin
    vec_t e;

    // Restart/done sequence, end=5, end_count changes after start ignored.
    add(A_START, 5, 0, 1, 0, 0, 0, 0, 0);
    add(A_FRAME, 0, 1, 1, 0, 1, 0, 0, 0);
    add(A_FRAME, 0, 2, 1, 0, 1, 0, 0, 0);
    add(A_FRAME, 0, 3, 1, 0, 1, 1, 0, 1);
    add(A_FRAME, 0, 4, 1, 0, 1, 0, 0, 1);
    add(A_FRAME, 0, 5, 1, 0, 1, 0, 0, 1);
    add(A_FRAME, 0, 5, 0, 1, 0, 0, 1, 1);
    add(A_FRAME, 0, 5, 0, 1, 0, 0, 0, 1);
    add(A_PAUSE_ON, 0, 5, 0, 1, 0, 0, 0, 1);
    add(A_PAUSE_OFF, 0, 5, 0, 1, 0, 0, 0, 1);
    // Beats with BEAT_FRAMES=3, end=10.
    add(A_START, 10, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      add(A_FRAME, 0, k, 1, 0, 1, (k % 3 == 0) ? 1 : 0, 0, k / 3);
    // Pause at 4, frames while paused are discarded.
    add(A_START, 20, 0, 1, 0, 0, 0, 0, 0);
    add(A_FRAME, 0, 1, 1, 0, 1, 0, 0, 0);
    add(A_FRAME, 0, 2, 1, 0, 1, 0, 0, 0);
    add(A_FRAME, 0, 3, 1, 0, 1, 1, 0, 1);
    add(A_FRAME, 0, 4, 1, 0, 1, 0, 0, 1);
    add(A_PAUSE_ON, 0, 4, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++)
      add(A_FRAME, 0, 4, 0, 0, 0, 0, 0, 1);
    add(A_PAUSE_OFF, 0, 4, 1, 0, 0, 0, 0, 1);
    add(A_FRAME, 0, 5, 1, 0, 1, 0, 0, 1);
    add(A_FRAME, 0, 6, 1, 0, 1, 1, 0, 2);
    add(A_FRAME, 0, 7, 1, 0, 1, 0, 0, 2);
    // Start on the same edge as a tick at 7: restart at 0, no tick.
    add(A_COINCIDE, 20, 0, 1, 0, 0, 0, 0, 0);
    add(A_FRAME, 0, 1, 1, 0, 1, 0, 0, 0);
    add(A_ABORT, 0, 0, 0, 0, 0, 0, 0, 0);
    add(A_PAUSE_ON, 0, 0, 0, 0, 0, 0, 0, 0);
    add(A_PAUSE_OFF, 0, 0, 0, 0, 0, 0, 0, 0);
    // end_count=0, then abort+start together in DONE.
    add(A_START, 0, 0, 1, 0, 0, 0, 0, 0);
    add(A_FRAME, 0, 0, 0, 1, 0, 0, 1, 0);
    add(A_ABORT_START, 9, 0, 0, 0, 0, 0, 0, 0);
    add(A_FRAME, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state.
    cyc(2);
    chk("rst_un_time", int'(un_time), 0);
    chk("rst_beat_idx", int'(beat_idx), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_stop_sign", int'(stop_sign), 0);
    chk("rst_pulses", int'({frame_tick, beat, done_pulse}), 0);
    reset = 1'b1;
    cyc(2);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i]);
      apply(vecs[i].act, vecs[i].ec);
      e = exp_q.pop_front();
      chk($sformatf("v%0d un_time", i), int'(un_time), e.un);
      chk($sformatf("v%0d running", i), int'(running), e.run);
      chk($sformatf("v%0d stop_sign", i), int'(stop_sign), e.stop);
      chk($sformatf("v%0d frame_ticks", i), tk_n, e.tk);
      chk($sformatf("v%0d beats", i), bt_n, e.bt);
      chk($sformatf("v%0d done_pulses", i), dn_n, e.dn);
      chk($sformatf("v%0d beat_idx", i), int'(beat_idx), e.idx);
    end

    // Asynchronous reset in the middle of RUN.
    apply(A_START, 16'd50);
    apply(A_FRAME, 16'd0);
    apply(A_FRAME, 16'd0);
    chk("pre_reset_un", int'(un_time), 2);
    chk("pre_reset_running", int'(running), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_un", int'(un_time), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_stop", int'(stop_sign), 0);
    @(negedge clk);
    reset = 1'b1;
    apply(A_FRAME, 16'd0);
    chk("post_reset_un", int'(un_time), 0);
    chk("post_reset_running", int'(running), 0);
    chk("post_reset_ticks", tk_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_game_timer.md
# frame_game_timer

Parametrised song/game timer that counts display frames from a start command up to a runtime-programmable end count. It adds pause/resume, abort, restart, beat pulses and a one-cycle done pulse. The block runs entirely in the `clk` domain: `new_frame` is a level input (vsync-derived) that is synchronised and edge-detected internally, not used as a clock. It sits between the game control FSM and the note/score logic, which consume `un_time`, `frame_tick` and `beat`.

## Interface
- `WIDTH`, 16, width of `un_time` and `end_count`
- `BEAT_FRAMES`, 30, frames per beat pulse; must be ≥1
- `BEAT_W`, 8, width of `beat_idx`
- `clk`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle start/restart command
- `pause`  input  1  level; high holds the timer
- `abort`  input  1  one-cycle command; return to idle
- `new_frame`  input  1  asynchronous frame level; its rising edge is one frame
- `end_count`  input  WIDTH  last frame value; sampled on accepted `start`
- `un_time`  output  WIDTH  current frame count
- `frame_tick`  output  1  pulse in the cycle `un_time` shows an incremented value
- `beat`  output  1  pulse when `un_time` becomes a nonzero multiple of `BEAT_FRAMES`
- `beat_idx`  output  BEAT_W  beats elapsed since start; wraps modulo 2^BEAT_W
- `running`  output  1  high in RUN
- `stop_sign`  output  1  high in DONE
- `done_pulse`  output  1  one-cycle pulse on entry to DONE

## Operation
- States are IDLE, RUN, PAUSE and DONE. Reset (`reset`=0) forces IDLE.
- Reset values:
  - `un_time`=0, `beat_idx`=0, end register=0, beat counter=0.
  - All 1-bit outputs are 0.
  - Sync flops are 0.
- Command priority each cycle is `abort` > `start` > `pause` > frame tick.
- `abort` in any state:
  - Go to IDLE.
  - Clear `un_time`, `beat_idx` and the beat counter.
- `start` in any state other than abort:
  - Latch `end_count`.
  - Clear `un_time`, `beat_idx` and the beat counter.
  - Go to RUN. This includes restarting from RUN, PAUSE or DONE.
- In RUN with `pause`=1: go to PAUSE. A frame tick in the same cycle is dropped.
- In PAUSE with `pause`=0: go to RUN. Ticks during PAUSE are discarded, not queued.
- In RUN with a frame tick and `pause`=0:
  - If `un_time`==end: go to DONE, hold `un_time`, pulse `done_pulse`. No `frame_tick` is issued.
  - Otherwise: `un_time`+1, pulse `frame_tick`, advance the beat counter.
- Beat counter:
  - Counts 0..BEAT_FRAMES-1.
  - On wrap to 0, pulse `beat` and increment `beat_idx`.
- `end_count`=0: the first tick after start goes directly to DONE.
- `un_time` never wraps, because it stops at end ≤ 2^WIDTH-1.
- `end_count` changes after start have no effect.
- `pause` is ignored in IDLE and DONE.

## Timing
- `new_frame` path:
  - Two synchroniser flops (s1, s2) plus a delay flop (s3).
  - Internal tick = s2 & ~s3.
- Latency: `new_frame` rising before clk edge k gives an internal tick in the cycle after edge k+1. The counter, `frame_tick`, `beat` and `done_pulse` update at edge k+2.
- `new_frame` must stay high and then low for ≥3 `clk` cycles each. Shorter pulses may be lost.
- All outputs are registered; there are no combinational input-to-output paths.
- Command timing:
  - `start` and `abort` take effect at the clock edge on which they are sampled.
  - `running`/`stop_sign` change at the same edge.
- A tick coinciding with `start` is dropped, so the count restarts at 0.
- Asynchronous reset mid-run:
  - All state clears immediately.
  - After release, the first clk edge behaves as IDLE.

## Structure
- Package `timer_pkg`:
  - `timer_state_t` enum {IDLE, RUN, PAUSE, DONE} (2-bit).
  - Default constants `TIMER_WIDTH`=16, `TIMER_BEAT_FRAMES`=30.
- Sub-module `frame_edge_sync`:
  - Contains the 2-flop synchroniser and rising-edge detector.
  - Ports: `clk`, `reset`, `async_in`, `rise_pulse`.
  - Reused for other vsync consumers.
- Top level: FSM, counters, end register and output registers.

## Test plan
- Reset, then `start` with `end_count`=5, then 7 frames → `un_time` 1,2,3,4,5. The 6th frame gives `done_pulse`, `stop_sign`=1, `un_time` holds at 5. The 7th frame: no change.
- `BEAT_FRAMES`=3, `end_count`=10, 10 frames → `beat` on `un_time`=3, 6, 9; `beat_idx` ends at 3.
- Pause after `un_time`=4, 5 frames while paused, release → `un_time` stays 4 during pause. The next frame after release gives 5.
- `start` and a frame edge on the same cycle while in RUN at 7 → `un_time`=0 and no `frame_tick` that cycle. The next frame gives 1.
- `abort` together with `start` while in DONE → IDLE, `un_time`=0, `stop_sign`=0, `running`=0.
- `end_count`=0 → the first frame gives DONE with `un_time`=0. Asserting `reset`=0 mid-RUN clears all outputs asynchronously, before the next clk edge.
